// File: rtl/seq_det_sched.sv
// Multi-channel round-robin scheduler feeding per-channel "1101" overlapping sequence detectors.
// Optional idle-sleep gating is enabled by defining SEQ_DET_SCHED_SLEEP_EN.
module seq_det_sched #(
  parameter int NCH      = 4,
  parameter int IDLE_CYC = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NCH-1:0]          in_valid,
  input  logic [NCH-1:0]          in_bit,
  output logic [NCH-1:0]          in_ready,
  input  logic [NCH-1:0]          ch_clr,
  output logic                    match_valid,
  output logic [$clog2(NCH)-1:0]  match_ch,
  output logic                    sleep
);

  localparam int CW = $clog2(NCH);

  typedef enum logic [1:0] {
    S0 = 2'b00,
    S1 = 2'b01,
    S2 = 2'b10,
    S3 = 2'b11
  } det_state_t;

  det_state_t      ctx_q [NCH];
  logic [CW-1:0]   last_q;
  logic [CW-1:0]   grant_idx;
  logic            grant_found;
  logic            consume;
  logic            hit;

  function automatic det_state_t det_next(input det_state_t s, input logic b);
    det_state_t n;
    case (s)
      S0:      n = b ? S1 : S0;
      S1:      n = b ? S2 : S0;
      S2:      n = b ? S2 : S3;
      S3:      n = b ? S1 : S0;
      default: n = S0;
    endcase
    return n;
  endfunction

  // Round-robin search starting one past the last consumed channel.
  always_comb begin
    logic [CW:0] sum;
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    grant_found = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int k = 0; k < NCH; k++) begin
      sum = {1'b0, last_q} + (CW+1)'(k + 1);
      if (sum >= (CW+1)'(NCH)) begin
        sum = sum - (CW+1)'(NCH);
      end
      if (!grant_found && in_valid[sum[CW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = sum[CW-1:0];
      end
    end
  end

  always_comb begin
    in_ready = '0;
    if (reset && grant_found && !sleep) begin
      in_ready = NCH'(1) << grant_idx;
    end
  end

  assign consume = |(in_valid & in_ready);

  // A clear on the consuming channel wins over the detection.
  assign hit = consume && (ctx_q[grant_idx] == S3) && in_bit[grant_idx] && !ch_clr[grant_idx];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q      <= CW'(NCH - 1);
      match_valid <= 1'b0;
      match_ch    <= '0;
    end else begin
      if (consume) begin
        last_q <= grant_idx;
      end
      match_valid <= hit;
      match_ch    <= hit ? grant_idx : '0;
    end
  end

  // NOTE: the context array is deliberately reset: a half-seen pattern must not
  // survive reset, so this storage cannot be left uninitialised like a data RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NCH; i++) begin
        ctx_q[i] <= S0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_clr[i]) begin
          ctx_q[i] <= S0;
        end else if (consume && (grant_idx == CW'(i))) begin
          ctx_q[i] <= det_next(ctx_q[i], in_bit[i]);
        end
      end
    end
  end

`ifdef SEQ_DET_SCHED_SLEEP_EN
  logic [7:0] idle_q;
  logic [7:0] idle_d;
  logic       sleep_q;

  always_comb begin
    idle_d = '0;
    if (in_valid == '0) begin
      idle_d = (idle_q == 8'(IDLE_CYC)) ? idle_q : idle_q + 8'd1;
    end
  end

  // Sleep follows the saturated idle count; any request drops it one edge later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idle_q  <= '0;
      sleep_q <= 1'b0;
    end else begin
      idle_q  <= idle_d;
      sleep_q <= (in_valid == '0) && (idle_d == 8'(IDLE_CYC));
    end
  end

  assign sleep = sleep_q;
`else
  assign sleep = 1'b0;
`endif

endmodule

// File: tb/tb_seq_det_sched.sv
// Scoreboard bench for seq_det_sched: stimulus pushes expected matches, a monitor pops them.
module tb_seq_det_sched;

  localparam int NCH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [NCH-1:0]   in_valid;
  logic [NCH-1:0]   in_bit;
  logic [NCH-1:0]   in_ready;
  logic [NCH-1:0]   ch_clr;
  logic             match_valid;
  logic [1:0]       match_ch;
  logic             sleep;

  seq_det_sched #(.NCH(NCH), .IDLE_CYC(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_bit      (in_bit),
    .in_ready    (in_ready),
    .ch_clr      (ch_clr),
    .match_valid (match_valid),
    .match_ch    (match_ch),
    .sleep       (sleep)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every match pulse must correspond to the oldest expected entry.
  always @(negedge clk) begin
    if (reset && match_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_match: got ch %0d at cycle %0d expected none", match_ch, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("match_ch", 32'(match_ch), 32'(e.ch));
        check("match_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the consuming edge.
  task automatic send(input int ch, input logic b, input logic clr, input logic exp_match);
    int n;
    in_valid     = '0;
    in_valid[ch] = 1'b1;
    in_bit       = '0;
    in_bit[ch]   = b;
    ch_clr       = '0;
    ch_clr[ch]   = clr;
    n = 0;
    @(negedge clk);
    while (!in_ready[ch] && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready[ch]) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: ch %0d in_ready %b expected grant", ch, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = '0;
    ch_clr   = '0;
    if (exp_match) begin
      sb.push_back('{ch: ch, cyc: cyc});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    in_valid = '1;
    in_bit   = '0;
    ch_clr   = '0;
    reset    = 1'b0;

    // Reset state, with requests present to prove grants are gated.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_match_valid", 32'(match_valid), 32'h0);
    check("rst_match_ch", 32'(match_ch), 32'h0);
    check("rst_sleep", 32'(sleep), 32'h0);

    // Round-robin with all four channels valid, starting at channel 0.
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("rr_grant_%0d", k), 32'(in_ready), 32'(1 << (k % 4)));
      @(posedge clk);
      #1;
    end
    in_valid = '0;

    // Channel 0 overlapping pattern: 1,1,0,1,1,0,1 -> matches on 4th and 7th.
    send(0, 1'b1, 1'b0, 1'b0);
    send(0, 1'b1, 1'b0, 1'b0);
    send(0, 1'b0, 1'b0, 1'b0);
    send(0, 1'b1, 1'b0, 1'b1);
    send(0, 1'b1, 1'b0, 1'b0);
    send(0, 1'b0, 1'b0, 1'b0);
    send(0, 1'b1, 1'b0, 1'b1);

    // Channel 1 pattern interleaved with channel 2 zeros.
    send(1, 1'b1, 1'b0, 1'b0);
    send(2, 1'b0, 1'b0, 1'b0);
    send(1, 1'b1, 1'b0, 1'b0);
    send(2, 1'b0, 1'b0, 1'b0);
    send(1, 1'b0, 1'b0, 1'b0);
    send(2, 1'b0, 1'b0, 1'b0);
    send(1, 1'b1, 1'b0, 1'b1);
    // Channel 2 must still be at S0: a fresh 1101 matches only on its last bit.
    send(2, 1'b1, 1'b0, 1'b0);
    send(2, 1'b1, 1'b0, 1'b0);
    send(2, 1'b0, 1'b0, 1'b0);
    send(2, 1'b1, 1'b0, 1'b1);

    // Channel 0 is at S1: drive to S3, then a cleared consume of 1 must not match.
    send(0, 1'b1, 1'b0, 1'b0);
    send(0, 1'b0, 1'b0, 1'b0);
    send(0, 1'b1, 1'b1, 1'b0);
    send(0, 1'b1, 1'b0, 1'b0);
    send(0, 1'b1, 1'b0, 1'b0);
    send(0, 1'b0, 1'b0, 1'b0);
    send(0, 1'b1, 1'b0, 1'b1);

    // Clear without a consume: channel 3 at S3 is forced back to S0.
    send(3, 1'b1, 1'b0, 1'b0);
    send(3, 1'b1, 1'b0, 1'b0);
    send(3, 1'b0, 1'b0, 1'b0);
    ch_clr = 4'b1000;
    @(posedge clk);
    #1;
    ch_clr = '0;
    send(3, 1'b1, 1'b0, 1'b0);

    // Channel 3 to S3 again, then reset mid-stream.
    send(3, 1'b1, 1'b0, 1'b0);
    send(3, 1'b1, 1'b0, 1'b0);
    send(3, 1'b0, 1'b0, 1'b0);
    in_valid = 4'b1000;
    in_bit   = 4'b1000;
    reset    = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", 32'(in_ready), 32'h0);
    check("midrst_match_valid", 32'(match_valid), 32'h0);
    @(posedge clk);
    #1;
    reset    = 1'b1;
    in_valid = '0;
    in_bit   = '0;
    send(3, 1'b1, 1'b0, 1'b0);
    // Channel 0 was at S1 before reset; 1,0,1 matches only if that survived.
    send(0, 1'b1, 1'b0, 1'b0);
    send(0, 1'b0, 1'b0, 1'b0);
    send(0, 1'b1, 1'b0, 1'b0);
    // Channel 3 now at S1: 1,0,1 completes a pattern.
    send(3, 1'b1, 1'b0, 1'b0);
    send(3, 1'b0, 1'b0, 1'b0);
    send(3, 1'b1, 1'b0, 1'b1);

`ifdef SEQ_DET_SCHED_SLEEP_EN
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 7) check("sleep_before_limit", 32'(sleep), 32'h0);
      if (k == 8) check("sleep_at_limit", 32'(sleep), 32'h1);
    end
    @(posedge clk);
    #1;
    in_valid = 4'b0100;
    in_bit   = '0;
    @(negedge clk);
    check("sleep_gated_ready", 32'(in_ready), 32'h0);
    check("sleep_still_high", 32'(sleep), 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("wake_sleep", 32'(sleep), 32'h0);
    check("wake_ready", 32'(in_ready), 32'h4);
    @(posedge clk);
    #1;
    in_valid = '0;
`else
    repeat (12) @(posedge clk);
    @(negedge clk);
    check("nosleep_sleep", 32'(sleep), 32'h0);
    @(posedge clk);
    #1;
    in_valid = 4'b0100;
    in_bit   = '0;
    @(negedge clk);
    check("nosleep_ready", 32'(in_ready), 32'h4);
    @(posedge clk);
    #1;
    in_valid = '0;
`endif

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_det_sched.md
SEQ_DET_SCHED -- requirements
Module: seq_det_sched

Interface
REQ-001 SHALL have parameter NCH, default 4, meaning number of serial-bit requester channels (legal values 2..8).
REQ-002 SHALL have parameter IDLE_CYC, default 8, meaning consecutive idle cycles before sleep (legal values 1..255).
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, NCH bits: channel i presents a bit.
REQ-006 SHALL have port in_bit, input, NCH bits: serial data bit of channel i.
REQ-007 SHALL have port in_ready, output, NCH bits: one-hot-or-zero grant; channel i's bit is consumed when in_valid[i] and in_ready[i] are both high.
REQ-008 SHALL have port ch_clr, input, NCH bits: clears channel i's detector context.
REQ-009 SHALL have port match_valid, output, 1 bit: one-cycle pulse indicating a detected 1101 pattern.
REQ-010 SHALL have port match_ch, output, clog2(NCH) bits: channel that produced the match; valid only while match_valid is high.
REQ-011 SHALL have port sleep, output, 1 bit: the block is idle and all grants are gated.

Function
REQ-012 SHALL keep one 2-bit detector context per channel, with states S0=00, S1=01, S2=10, S3=11.
REQ-013 SHALL update only the context of the channel whose bit is consumed, using these transitions (bit=1 / bit=0):
- S0 -> S1 / S0
- S1 -> S2 / S0
- S2 -> S2 / S3
- S3 -> S1 / S0
REQ-014 SHALL detect overlapping occurrences: consuming bit=1 while the context is S3 is a match.
REQ-015 SHALL register the match, so match_valid pulses exactly 1 cycle after the consuming edge, with match_ch equal to the consumed channel.
REQ-016 SHALL grant round-robin: the search starts at (last_granted+1) mod NCH; in_ready is driven combinationally to the first channel with in_valid set.
REQ-017 SHALL update last_granted only on a consume; last_granted resets to NCH-1, so channel 0 has first priority.
REQ-018 SHALL drive in_ready to all zeros when in_valid is all zeros or sleep is high.
REQ-019 SHALL, when ch_clr[i] is high, force context i to S0 at the next edge.
REQ-020 SHALL, when ch_clr[i] coincides with a consume on channel i, still consume the bit, set the context to S0, and suppress the match.
REQ-021 SHALL hold a bit in a channel whose in_valid is high but which is not granted; that channel's context is unchanged.

Reset
REQ-022 SHALL, while reset is low, set all contexts to S0, match_valid=0, match_ch=0, last_granted=NCH-1, idle counter=0 and sleep=0, and drive in_ready to all zeros.
REQ-023 SHALL discard any partially detected sequence when reset is asserted mid-stream, and SHALL emit no match for bits consumed before reset.
REQ-024 SHALL make the first grant possible in the first cycle after reset deasserts.

Configuration
REQ-025 SHALL use the macro SEQ_DET_SCHED_SLEEP_EN.
REQ-026 SHALL, with SEQ_DET_SCHED_SLEEP_EN defined, behave as follows:
- An 8-bit idle counter increments on each cycle with in_valid all zeros, saturating at IDLE_CYC, and clears on any nonzero in_valid.
- sleep is registered high on the edge where the counter reaches IDLE_CYC.
- While sleep is high, a nonzero in_valid clears sleep at the next edge, and grants resume in that following cycle (1-cycle wake penalty).
- Contexts are retained through sleep.
REQ-027 SHALL, without SEQ_DET_SCHED_SLEEP_EN, tie sleep to 0, omit the idle counter, and make grants never gated.

Verification
REQ-028 SHALL cover: channel 0 alone streams 1,1,0,1,1,0,1 -> match_valid pulses with match_ch=0 one cycle after the 4th and 7th consumes (overlap).
REQ-029 SHALL cover: channels 0..3 all held valid for 8 cycles -> in_ready order 0,1,2,3,0,1,2,3, one consume per cycle.
REQ-030 SHALL cover: channel 1 streams 1,1,0 while channel 2 interleaves 0s, then channel 1 sends 1 -> match_ch=1, and channel 2 context remains S0.
REQ-031 SHALL cover: channel 0 at S3 consumes 1 with ch_clr[0]=1 on the same cycle -> no match, context S0, and a subsequent 1,1,0,1 matches.
REQ-032 SHALL cover: reset pulsed low after channel 3 sent 1,1,0, then 1 sent after reset -> no match.
REQ-033 SHALL cover, with SEQ_DET_SCHED_SLEEP_EN and IDLE_CYC=8: 8 idle cycles -> sleep=1; then in_valid[2]=1 -> sleep=0 next edge, in_ready[2]=1 the cycle after.
